// File: rtl/fifo_arb_rx.sv
// Receive-side frame demultiplexer: drains framed bytes from a host FIFO and
// steers each whole frame (header + payload) into one of two client FIFOs.

package host_fifo_pkg;
  localparam int FIFO_CNT_WIDTH     = 3;
  localparam int FIFO_PAYLOAD_WIDTH = 3;
  localparam logic [FIFO_CNT_WIDTH-1:0] CMASK = '1;

  // Payload byte count carried by a header CNT code (code 0 = header-only frame).
  function automatic logic [FIFO_PAYLOAD_WIDTH-1:0] fifo_payload(
    input logic [FIFO_CNT_WIDTH-1:0] code
  );
    return code;
  endfunction
endpackage

module fifo #(
  parameter int DEPTH_WIDTH = 3,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);
  localparam int DEPTH = 2 ** DEPTH_WIDTH;

  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]  mem_d [DEPTH];
  logic [DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_WIDTH:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
  logic                   do_wr, do_rd;

  assign full    = cnt_q[DEPTH_WIDTH];
  assign empty   = (cnt_q == '0);
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = rd_data_q;

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    rd_data_d = rd_data_q;
    if (do_wr) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_rd) begin
      rd_data_d = mem_q[rd_ptr_q];
      rd_ptr_d  = rd_ptr_q + 1'b1;
    end
    if (do_wr && !do_rd)      cnt_d = cnt_q + 1'b1;
    else if (!do_wr && do_rd) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

module fifo_arb_rx
  import host_fifo_pkg::*;
#(
  parameter int                DWIDTH  = 8,
  parameter logic [DWIDTH-1:0] SELMASK = 8'h80,
  parameter logic [DWIDTH-1:0] CNTMASK = 8'h70,
  parameter int                AWIDTH  = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              fifo_rdempty,
  input  logic [DWIDTH-1:0] fifo_rddata,
  output logic              fifo_rden,
  input  logic              c1_rden,
  output logic [DWIDTH-1:0] c1_rddata,
  output logic              c1_rdempty,
  input  logic              c2_rden,
  output logic [DWIDTH-1:0] c2_rddata,
  output logic              c2_rdempty,
  output logic              busy
);
  localparam int CSHIFT = $clog2(CNTMASK) - FIFO_CNT_WIDTH;
  localparam int NCL    = 2;

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_e;

  state_e                        state_q, state_d;
  logic [FIFO_PAYLOAD_WIDTH-1:0] rem_q, rem_d, hdr_n;
  logic [FIFO_CNT_WIDTH-1:0]     hdr_code;
  logic                          dest_c1_q, dest_c1_d;
  logic                          skid_vld_q, skid_vld_d;
  logic [DWIDTH-1:0]             skid_data_q, skid_data_d;
  logic                          in_flight_q;
  logic                          hdr_c1, arr_c1, dest_full, arr_full;
  logic                          wr_en, wr_c1;
  logic [DWIDTH-1:0]             wr_data;

  // Index 0 is client 1, index 1 is client 2.
  logic [NCL-1:0]             cl_wr, cl_rden, cl_full, cl_empty;
  logic [NCL-1:0][DWIDTH-1:0] cl_rddata;

  assign hdr_code  = FIFO_CNT_WIDTH'(fifo_rddata >> CSHIFT) & CMASK;
  assign hdr_n     = fifo_payload(hdr_code);
  assign hdr_c1    = ((fifo_rddata & SELMASK) == SELMASK);
  // The header byte is steered by its own decode, everything else by the latched dest.
  assign arr_c1    = (state_q == HDR) ? hdr_c1 : dest_c1_q;
  assign dest_full = dest_c1_q ? cl_full[0] : cl_full[1];
  assign arr_full  = arr_c1 ? cl_full[0] : cl_full[1];

  assign fifo_rden = ~fifo_rdempty & (state_q != HDR) & ~skid_vld_q
                   & ~(in_flight_q & dest_full);
  assign busy      = (state_q != IDLE) | in_flight_q | skid_vld_q;

  // Skid never coexists with an arriving byte: the read gate closes whenever it could fill.
  always_comb begin
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    wr_en       = 1'b0;
    wr_c1       = arr_c1;
    wr_data     = fifo_rddata;
    if (skid_vld_q) begin
      wr_c1   = dest_c1_q;
      wr_data = skid_data_q;
      if (!dest_full) begin
        wr_en      = 1'b1;
        skid_vld_d = 1'b0;
      end
    end else if (in_flight_q) begin
      if (!arr_full) begin
        wr_en = 1'b1;
      end else begin
        skid_vld_d  = 1'b1;
        skid_data_d = fifo_rddata;
      end
    end
  end

  assign cl_wr = wr_en ? (wr_c1 ? 2'b01 : 2'b10) : 2'b00;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    dest_c1_d = dest_c1_q;
    case (state_q)
      IDLE: if (fifo_rden) state_d = HDR;
      HDR: if (in_flight_q) begin
        dest_c1_d = hdr_c1;
        if (hdr_n == '0) begin
          state_d = IDLE;
        end else begin
          rem_d   = hdr_n;
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: if (fifo_rden) begin
        rem_d = rem_q - 1'b1;
        if (rem_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      dest_c1_q   <= 1'b0;
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
      in_flight_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      dest_c1_q   <= dest_c1_d;
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
      in_flight_q <= fifo_rden;
    end
  end

  assign cl_rden = {c2_rden, c1_rden};

  for (genvar g = 0; g < NCL; g++) begin : g_cl
    fifo #(.DEPTH_WIDTH(AWIDTH), .DATA_WIDTH(DWIDTH)) u_fifo (
      .clk     (CLK),
      .rst     (RESET),
      .wr_en   (cl_wr[g]),
      .wr_data (wr_data),
      .rd_en   (cl_rden[g]),
      .rd_data (cl_rddata[g]),
      .full    (cl_full[g]),
      .empty   (cl_empty[g])
    );
  end

  assign c1_rddata  = cl_rddata[0];
  assign c1_rdempty = cl_empty[0];
  assign c2_rddata  = cl_rddata[1];
  assign c2_rdempty = cl_empty[1];
endmodule

// File: tb/tb_fifo_arb_rx.sv
// Directed bench for fifo_arb_rx: per-frame vector table plus hand sequences
// for backpressure, head-of-line blocking, throughput and mid-frame reset.

module tb_fifo_arb_rx;
  logic       CLK = 1'b0;
  logic       RESET;
  logic       fifo_rdempty;
  logic [7:0] fifo_rddata = '0;
  logic       fifo_rden;
  logic       c1_rden, c2_rden;
  logic [7:0] c1_rddata, c2_rddata;
  logic       c1_rdempty, c2_rdempty;
  logic       busy;

  always #5 CLK = ~CLK;

  fifo_arb_rx dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .fifo_rdempty (fifo_rdempty),
    .fifo_rddata  (fifo_rddata),
    .fifo_rden    (fifo_rden),
    .c1_rden      (c1_rden),
    .c1_rddata    (c1_rddata),
    .c1_rdempty   (c1_rdempty),
    .c2_rden      (c2_rden),
    .c2_rddata    (c2_rddata),
    .c2_rdempty   (c2_rdempty),
    .busy         (busy)
  );

  // Upstream FIFO model: data valid the cycle after a pop, flushed by RESET.
  logic [7:0] up_mem [0:255];
  int up_wr = 0, up_rd = 0, n_rden = 0;
  assign fifo_rdempty = (up_rd == up_wr);

  always @(posedge CLK) begin
    if (RESET) up_rd <= up_wr;
    else if (fifo_rden && up_rd != up_wr) begin
      fifo_rddata <= up_mem[up_rd[7:0]];
      up_rd       <= up_rd + 1;
    end
  end

  always @(posedge CLK) if (!RESET && fifo_rden) n_rden++;

  typedef struct {
    logic [7:0] hdr;
    int         n;
    bit         to_c1;
    int         lat;
  } vec_t;

  vec_t vecs [8];
  int n_vec = 0, n_err = 0;
  int r0, t0, cyc, cnt;
  bit done;
  logic [10:0] pat;
  logic [7:0] exp3 [10];
  logic [7:0] exp4 [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    up_mem[up_wr[7:0]] = b;
    up_wr++;
  endtask

  task automatic pop_chk(input bit to_c1, input logic [7:0] exp, input string name);
    int w = 0;
    while ((to_c1 ? c1_rdempty : c2_rdempty) && w < 30) begin
      tick();
      w++;
    end
    chk({name, " ready"}, 32'(to_c1 ? c1_rdempty : c2_rdempty), 32'd0);
    if (to_c1) c1_rden = 1'b1;
    else       c2_rden = 1'b1;
    tick();
    c1_rden = 1'b0;
    c2_rden = 1'b0;
    chk(name, 32'(to_c1 ? c1_rddata : c2_rddata), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{hdr: 8'h85, n: 0, to_c1: 1'b1, lat: 2};
    vecs[1] = '{hdr: 8'h12, n: 1, to_c1: 1'b0, lat: 4};
    vecs[2] = '{hdr: 8'hA0, n: 2, to_c1: 1'b1, lat: 5};
    vecs[3] = '{hdr: 8'h7F, n: 7, to_c1: 1'b0, lat: 10};
    vecs[4] = '{hdr: 8'hF3, n: 7, to_c1: 1'b1, lat: 10};
    vecs[5] = '{hdr: 8'h40, n: 4, to_c1: 1'b0, lat: 7};
    vecs[6] = '{hdr: 8'h80, n: 0, to_c1: 1'b1, lat: 2};
    vecs[7] = '{hdr: 8'h00, n: 0, to_c1: 1'b0, lat: 2};
    exp3 = '{8'hB0, 8'h31, 8'h32, 8'h33, 8'hD0, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55};
    exp4 = '{8'h70, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
             8'h30, 8'hC0, 8'hC1, 8'hC2};

    RESET = 1'b1; c1_rden = 1'b0; c2_rden = 1'b0;
    repeat (3) tick();
    RESET = 1'b0;
    chk("reset rden",     32'(fifo_rden),  32'd0);
    chk("reset c1 empty", 32'(c1_rdempty), 32'd1);
    chk("reset c2 empty", 32'(c2_rdempty), 32'd1);
    chk("reset busy",     32'(busy),       32'd0);

    // Single frames into empty clients: routing, pop count, latency, data order.
    for (int v = 0; v < 8; v++) begin
      r0 = n_rden;
      push(vecs[v].hdr);
      for (int i = 0; i < vecs[v].n; i++) push(8'(8'hA0 + 8 * v + i));
      #1;
      t0 = -1; done = 1'b0; cyc = 0;
      while (!done && cyc < 60) begin
        if (fifo_rden && t0 < 0) t0 = cyc;
        if (t0 >= 0 && cyc > t0 && !busy && fifo_rdempty) done = 1'b1;
        else begin
          tick();
          cyc++;
        end
      end
      chk($sformatf("v%0d idle", v),    32'(done),       32'd1);
      chk($sformatf("v%0d latency", v), cyc - t0,        vecs[v].lat);
      chk($sformatf("v%0d pops", v),    n_rden - r0,     vecs[v].n + 1);
      chk($sformatf("v%0d other empty", v),
          32'(vecs[v].to_c1 ? c2_rdempty : c1_rdempty), 32'd1);
      pop_chk(vecs[v].to_c1, vecs[v].hdr, $sformatf("v%0d hdr", v));
      for (int i = 0; i < vecs[v].n; i++)
        pop_chk(vecs[v].to_c1, 8'(8'hA0 + 8 * v + i), $sformatf("v%0d pl%0d", v, i));
      chk($sformatf("v%0d drained", v),
          32'(vecs[v].to_c1 ? c1_rdempty : c2_rdempty), 32'd1);
    end

    // Client 1 never read: 8 land in the FIFO, the 9th sits in the skid.
    r0 = n_rden;
    for (int i = 0; i < 10; i++) push(exp3[i]);
    repeat (30) tick();
    chk("t3 pops while full", n_rden - r0, 9);
    chk("t3 busy", 32'(busy), 32'd1);
    cnt = 0;
    repeat (8) begin
      tick();
      if (fifo_rden) cnt++;
    end
    chk("t3 rden held low", cnt, 0);
    for (int i = 0; i < 10; i++) pop_chk(1'b1, exp3[i], $sformatf("t3 byte%0d", i));
    repeat (5) tick();
    chk("t3 pops total", n_rden - r0, 10);
    chk("t3 c1 empty", 32'(c1_rdempty), 32'd1);
    chk("t3 c2 empty", 32'(c2_rdempty), 32'd1);
    chk("t3 idle",     32'(busy),       32'd0);

    // Head-of-line: full c2 stalls its frame and the trailing c1 frame.
    r0 = n_rden;
    for (int i = 0; i < 8; i++) push(exp4[i]);
    push(8'h80);
    for (int i = 8; i < 12; i++) push(exp4[i]);
    push(8'h81);
    repeat (40) tick();
    chk("t4 pops stalled", n_rden - r0, 10);
    chk("t4 busy", 32'(busy), 32'd1);
    pop_chk(1'b1, 8'h80, "t4 c1 first");
    repeat (10) tick();
    chk("t4 c1 blocked", 32'(c1_rdempty), 32'd1);
    chk("t4 rden low",   32'(fifo_rden),  32'd0);
    for (int i = 0; i < 12; i++) pop_chk(1'b0, exp4[i], $sformatf("t4 c2 byte%0d", i));
    pop_chk(1'b1, 8'h81, "t4 c1 trailing");
    repeat (5) tick();
    chk("t4 pops total", n_rden - r0, 14);
    chk("t4 idle", 32'(busy), 32'd0);

    // Throughput: one bubble after the header pop, then a pop every cycle.
    c1_rden = 1'b1; c2_rden = 1'b1;
    push(8'hF0);
    for (int i = 0; i < 7; i++) push(8'(8'h71 + i));
    #1;
    for (int c = 0; c < 11; c++) begin
      pat[c] = fifo_rden;
      tick();
    end
    chk("t5 rden pattern", 32'(pat), 32'(11'b00111111101));
    repeat (4) tick();
    c1_rden = 1'b0; c2_rden = 1'b0;
    tick();
    chk("t5 c1 empty", 32'(c1_rdempty), 32'd1);
    chk("t5 idle",     32'(busy),       32'd0);

    // Reset in the middle of a payload.
    push(8'hF0);
    for (int i = 0; i < 7; i++) push(8'(8'h61 + i));
    #1;
    repeat (3) tick();
    chk("t6 busy before reset", 32'(busy), 32'd1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("t6 rden",     32'(fifo_rden),  32'd0);
    chk("t6 c1 empty", 32'(c1_rdempty), 32'd1);
    chk("t6 c2 empty", 32'(c2_rdempty), 32'd1);
    chk("t6 busy",     32'(busy),       32'd0);
    r0 = n_rden;
    push(8'h85);
    #1;
    repeat (6) tick();
    chk("t6 pops after reset", n_rden - r0, 1);
    pop_chk(1'b1, 8'h85, "t6 hdr to c1");
    chk("t6 c2 untouched", 32'(c2_rdempty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_arb_rx.md
Name: fifo_arb_rx

Overview:
- Receive-side counterpart of the tx arbiter. Drains one upstream framed byte stream from a host FIFO read port and demultiplexes whole frames (header + payload) into two per-client FIFOs.
- Routing uses the same header encoding as the tx side. A header matching SELMASK routes the frame to client 1; any other header routes it to client 2.
- Payload length comes from the header CNT field via host_fifo_pkg::fifo_payload().

Parameters:
- SELMASK, 8'h80: header bits that select client 1 when (hdr & SELMASK) == SELMASK.
- CNTMASK, 8'h70: contiguous CNT field, FIFO_CNT_WIDTH bits wide. CSHIFT = $clog2(CNTMASK) - FIFO_CNT_WIDTH.
- DWIDTH, 8: data width.
- AWIDTH, 3: address width of each internal client FIFO (depth 2**AWIDTH).

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- fifo_rdempty  in  1  upstream FIFO empty.
- fifo_rddata  in  DWIDTH  upstream read data, valid the cycle after fifo_rden.
- fifo_rden  out  1  upstream pop.
- c1_rden  in  1  client 1 pop.
- c1_rddata  out  DWIDTH  client 1 data, valid the cycle after c1_rden.
- c1_rdempty  out  1  client 1 FIFO empty.
- c2_rden  in  1  client 2 pop.
- c2_rddata  out  DWIDTH  client 2 data.
- c2_rdempty  out  1  client 2 FIFO empty.
- busy  out  1  frame in progress, read in flight, or skid occupied.

Behaviour:
- Clock and reset: single clock CLK. Reset is synchronous and active-high on RESET, and also drives the rst of both internal fifo instances (DEPTH_WIDTH=AWIDTH, DATA_WIDTH=DWIDTH).
- Reset values: fifo_rden=0, c1_rdempty=c2_rdempty=1, busy=0. Internal state: state=IDLE, rem=0, dest=c2, skid empty, in-flight flag 0.
- in_flight register: set the cycle after fifo_rden. Arriving byte = fifo_rddata while in_flight=1.
- Write path for an arriving byte:
  - Dest FIFO not full: write it there.
  - Otherwise: capture it in a 1-entry skid register.
  - Skid drains to the dest FIFO on the first cycle that FIFO is not full.
- Read gate: fifo_rden = ~fifo_rdempty & issue_ok & skid empty & ~(in_flight & dest_full). This guarantees no byte is ever dropped and at most one read is outstanding beyond skid capacity.
- FSM:
  - IDLE: when the read gate is open, pop the header and go to HDR.
  - HDR: waits for the header arrival; no rden issued. On arrival:
    - dest = ((hdr & SELMASK) == SELMASK) ? c1 : c2, registered.
    - N = fifo_payload((hdr >> CSHIFT) & CMASK).
    - Header is written or skidded to dest.
    - N == 0 goes to IDLE. Otherwise rem = N and go to PAYLOAD.
  - PAYLOAD: each rden decrements rem at issue time. The rden that brings rem to 0 goes to IDLE. The last byte lands the following cycle under the unchanged dest.
- Ordering and throughput:
  - Throughput: 1 payload byte per cycle when the dest FIFO has room. One bubble per frame for header decode.
  - Frames are delivered strictly in upstream order. A full destination blocks all later frames (head-of-line); the other client is not served out of order.
  - dest changes only on header arrival, and header pop is blocked while the skid is occupied. The skid therefore always belongs to the current dest.
- Widths: rem is FIFO_PAYLOAD_WIDTH bits. No wrap; rem never decrements below 0.
- Simultaneous client pop and arbiter write to the same FIFO in one cycle follow fifo semantics: both take effect and the count is unchanged.
- Reset mid-frame: all state is cleared and both client FIFOs are flushed. Any in-flight upstream byte is discarded. Upstream must be reset in the same cycle. The first byte popped after reset is treated as a header.
- busy = (state != IDLE) | in_flight | skid valid.

Test Plan (SELMASK=8'h80, CNTMASK=8'h70, DWIDTH=8, AWIDTH=3; golden N from host_fifo_pkg::fifo_payload):
1. Upstream holds 8'h85 (code 0) -> exactly one fifo_rden; c1 receives 8'h85; c2_rdempty stays 1; busy returns to 0 two cycles after rden.
2. Upstream holds 8'h12 (code 1, client 2) then N=fifo_payload(1) bytes 8'hA0,8'hA1,... -> c2 receives header then payload in order; c1_rdempty stays 1.
3. c1 never read; upstream has two c1 frames totalling 10 bytes ->
   - c1 FIFO holds the first 8 bytes, skid holds the 9th.
   - fifo_rden stays 0 while c1 is full.
   - Draining c1 then yields all 10 bytes in order, with no loss or duplication.
4. Frames c1(8'h80, code 0), c2(8'h30, code 3), c1(8'h81, code 0); c2 FIFO pre-filled full ->
   - c2 frame stalls mid-delivery and the trailing c1 frame is not delivered.
   - After c2 is drained, the c2 frame completes, then 8'h81 reaches c1.
5. Both clients draining continuously; upstream pre-loaded with code-7 frame -> fifo_rden asserted every cycle for all N payload bytes; exactly one idle cycle between header pop and first payload pop.
6. RESET pulsed one cycle during PAYLOAD with rem>0 -> next cycle fifo_rden=0, c1_rdempty=c2_rdempty=1, busy=0. A subsequent 8'h85 from a reset upstream is decoded as a header and routed to c1.
